// File: rtl/imem_loadable.sv
// imem_loadable
//   Run-time loadable instruction memory for the MIPS fetch stage.
//   The fetch side registers the word address (held while stall=1) and reads
//   the array combinationally from that register.
//   The loader side accepts a window of words over a valid/ready port.
//   Words are written sequentially from ld_base.
//   inst_valid drops while a load is in progress.
//
// Ports
//   clk, rst     single clock, synchronous active-high reset
//   addr, stall  fetch word address and address-hold request
//   inst         instruction at the registered address (NOP_WORD if out of range)
//   inst_valid   1 only while the loader is idle
//   ld_start     load request; ld_base/ld_count are sampled with it (idle only)
//   ld_data      load data word, qualified by ld_valid
//   ld_ready     loader is accepting words
//   ld_busy      a load is in progress or finishing
//   ld_done      one-cycle completion pulse
//   ld_err       sticky range error, cleared by the next accepted start
module imem_loadable #(
  parameter int                ADDR_W     = 30,
  parameter int                DEPTH_LOG2 = 10,
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] NOP_WORD   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  stall,
  output logic [DATA_W-1:0]     inst,
  output logic                  inst_valid,
  input  logic                  ld_start,
  input  logic [DEPTH_LOG2-1:0] ld_base,
  input  logic [DEPTH_LOG2:0]   ld_count,
  input  logic [DATA_W-1:0]     ld_data,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  output logic                  ld_busy,
  output logic                  ld_done,
  output logic                  ld_err
);

  localparam int                    DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2+1:0] DEPTH_EXT = (DEPTH_LOG2+2)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_p1;
  logic [DEPTH_LOG2-1:0]   ptr_q, ptr_d;
  logic [DEPTH_LOG2:0]     rem_q, rem_d;
  logic                    err_q, err_d;
  logic                    wr_en;
  logic [DEPTH_LOG2+1:0]   ld_end;
  logic [DATA_W-1:0]       mem [DEPTH];

  // Two guard bits so base+count cannot overflow before the range compare.
  assign ld_end = {2'b00, ld_base} + {1'b0, ld_count};
  assign ld_err = err_q;

  // Loader next-state and output decode
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rem_d      = rem_q;
    err_d      = err_q;
    wr_en      = 1'b0;
    inst_valid = 1'b0;
    ld_ready   = 1'b0;
    ld_busy    = 1'b0;
    ld_done    = 1'b0;
    case (state_q)
      IDLE: begin
        inst_valid = 1'b1;
        if (ld_start) begin
          if (ld_end > DEPTH_EXT) begin
            err_d = 1'b1;
          end else if (ld_count == '0) begin
            err_d   = 1'b0;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            ptr_d   = ld_base;
            rem_d   = ld_count;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        ld_ready = 1'b1;
        ld_busy  = 1'b1;
        if (ld_valid) begin
          wr_en = 1'b1;
          // ptr may step past the last index after the final word; it is
          // never used again before the next start reloads it.
          ptr_d = ptr_q + PTR_ONE;
          rem_d = rem_q - CNT_ONE;
          if (rem_q == CNT_ONE) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        ld_busy = 1'b1;
        ld_done = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Loader control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  // Memory array: not cleared by reset; a reset cycle aborts any pending write
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[ptr_q] <= ld_data;
    end
  end

  // Fetch stage p1: registered word address
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_p1 <= '0;
    end else if (!stall) begin
      addr_p1 <= addr;
    end
  end

  // Combinational read from the registered address
  always_comb begin
    inst = NOP_WORD;
    if (addr_p1[ADDR_W-1:DEPTH_LOG2] == '0) begin
      inst = mem[addr_p1[DEPTH_LOG2-1:0]];
    end
  end

endmodule

// File: tb/tb_imem_loadable.sv
// tb_imem_loadable
//   Scoreboard bench for imem_loadable. The driver steps a behavioural model
//   (an array of words plus a count of words still owed to the current load)
//   once per clock and pushes the expected outputs; a monitor on the falling
//   edge pops and compares them with the DUT.
module tb_imem_loadable;

  localparam int ADDR_W     = 30;
  localparam int DEPTH_LOG2 = 10;
  localparam int DATA_W     = 32;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [ADDR_W-1:0]     addr;
  logic                  stall;
  logic [DATA_W-1:0]     inst;
  logic                  inst_valid;
  logic                  ld_start;
  logic [DEPTH_LOG2-1:0] ld_base;
  logic [DEPTH_LOG2:0]   ld_count;
  logic [DATA_W-1:0]     ld_data;
  logic                  ld_valid;
  logic                  ld_ready;
  logic                  ld_busy;
  logic                  ld_done;
  logic                  ld_err;

  always #5 clk = ~clk;

  imem_loadable #(
    .ADDR_W    (ADDR_W),
    .DEPTH_LOG2(DEPTH_LOG2),
    .DATA_W    (DATA_W),
    .NOP_WORD  (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .stall     (stall),
    .inst      (inst),
    .inst_valid(inst_valid),
    .ld_start  (ld_start),
    .ld_base   (ld_base),
    .ld_count  (ld_count),
    .ld_data   (ld_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_busy   (ld_busy),
    .ld_done   (ld_done),
    .ld_err    (ld_err)
  );

  typedef struct {
    logic [DATA_W-1:0] inst;
    bit                known;
    bit                iv;
    bit                rdy;
    bit                busy;
    bit                done;
    bit                err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model
  logic [ADDR_W-1:0] m_addr;
  int                m_left;
  int                m_ptr;
  bit                m_done;
  bit                m_err;
  logic [DATA_W-1:0] m_mem   [DEPTH];
  bit                m_known [DEPTH];

  bit rand_fetch;
  int hot_base;

  task automatic chk(input string name, input logic [DATA_W-1:0] got,
                     input logic [DATA_W-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: actual %h required %h", name, $time, got, want);
    end
  endtask

  // The model is stepped with the inputs present at the clock edge.
  task automatic model_step();
    if (rst) begin
      m_addr = '0;
      m_left = 0;
      m_done = 1'b0;
      m_err  = 1'b0;
    end else begin
      if (!stall) m_addr = addr;
      if (m_done) begin
        m_done = 1'b0;
      end else if (m_left > 0) begin
        if (ld_valid) begin
          m_mem[m_ptr]   = ld_data;
          m_known[m_ptr] = 1'b1;
          m_ptr++;
          m_left--;
          if (m_left == 0) m_done = 1'b1;
        end
      end else if (ld_start) begin
        if (int'(ld_base) + int'(ld_count) > DEPTH) begin
          m_err = 1'b1;
        end else begin
          m_err = 1'b0;
          if (ld_count == 0) m_done = 1'b1;
          else begin
            m_ptr  = int'(ld_base);
            m_left = int'(ld_count);
          end
        end
      end
    end
  endtask

  function automatic exp_t expect_now();
    exp_t e;
    if (m_addr < DEPTH) begin
      e.inst  = m_mem[m_addr[DEPTH_LOG2-1:0]];
      e.known = m_known[m_addr[DEPTH_LOG2-1:0]];
    end else begin
      e.inst  = 32'h0000_0000;
      e.known = 1'b1;
    end
    e.busy = m_done || (m_left > 0);
    e.iv   = !e.busy;
    e.rdy  = (m_left > 0);
    e.done = m_done;
    e.err  = m_err;
    return e;
  endfunction

  task automatic set_fetch_rand();
    int r;
    if (rand_fetch) begin
      stall = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 9);
      if (r == 0)      addr = ADDR_W'($urandom);
      else if (r < 5)  addr = ADDR_W'(hot_base + $urandom_range(0, 7));
      else             addr = ADDR_W'($urandom_range(0, DEPTH - 1));
    end
  endtask

  task automatic cyc();
    set_fetch_rand();
    @(posedge clk);
    model_step();
    sb.push_back(expect_now());
    #1;
  endtask

  task automatic do_load(input int base, input int count, input int vpct);
    hot_base = base;
    ld_start = 1'b1;
    ld_base  = DEPTH_LOG2'(base);
    ld_count = (DEPTH_LOG2+1)'(count);
    ld_valid = 1'b1;            // ignored while idle
    ld_data  = $urandom;
    cyc();
    ld_start = 1'b0;
    for (int i = 0; i < count * 20 + 4 && (m_left > 0 || m_done); i++) begin
      ld_valid = ($urandom_range(0, 99) < vpct);
      ld_data  = $urandom;
      // Starts outside idle must be ignored.
      ld_start = ($urandom_range(0, 7) == 0);
      ld_base  = DEPTH_LOG2'($urandom);
      ld_count = (DEPTH_LOG2+1)'($urandom_range(0, 8));
      cyc();
    end
    ld_start = 1'b0;
    ld_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("inst_valid", 32'(inst_valid), 32'(mon_e.iv));
      chk("ld_ready",   32'(ld_ready),   32'(mon_e.rdy));
      chk("ld_busy",    32'(ld_busy),    32'(mon_e.busy));
      chk("ld_done",    32'(ld_done),    32'(mon_e.done));
      chk("ld_err",     32'(ld_err),     32'(mon_e.err));
      if (mon_e.known) chk("inst", inst, mon_e.inst);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared / %0d mismatched",
             n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int count;
    m_addr = '0; m_left = 0; m_ptr = 0; m_done = 1'b0; m_err = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]   = '0;
      m_known[i] = 1'b0;
    end
    rand_fetch = 1'b0;
    hot_base   = 0;
    rst = 1'b1; addr = '0; stall = 1'b0;
    ld_start = 1'b0; ld_base = '0; ld_count = '0; ld_data = '0; ld_valid = 1'b0;
    #1;
    cyc(); cyc();
    rst = 1'b0;

    // Fill the whole array (exact-fit boundary) with random words.
    rand_fetch = 1'b1;
    do_load(0, DEPTH, 75);

    // Reset, then a plain fetch of word 5.
    rst = 1'b1; cyc(); rst = 1'b0;
    rand_fetch = 1'b0;
    stall = 1'b0; addr = 30'd5; cyc(); cyc();

    // Stall holds the registered address.
    stall = 1'b1;
    addr = 30'd6; cyc();
    addr = 30'd7; cyc();
    addr = 30'd8; cyc();
    stall = 1'b0; cyc(); cyc();

    // Gapped three-word load at 8 while fetching word 9.
    addr = 30'd9;
    hot_base = 8;
    ld_start = 1'b1; ld_base = 10'd8; ld_count = 11'd3; cyc();
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 32'hAAAA_0001; cyc();
    ld_valid = 1'b0; ld_data = 32'hDEAD_BEEF; cyc();
    ld_valid = 1'b1; ld_data = 32'hBBBB_0002; cyc();
    ld_data  = 32'hCCCC_0003; cyc();
    ld_valid = 1'b0; cyc();
    cyc();
    addr = 30'd8; cyc();
    addr = 30'd10; cyc(); cyc();

    // Range errors and their clearing.
    rand_fetch = 1'b1;
    do_load(1020, 5, 80);
    cyc(); cyc();
    do_load(1020, 4, 80);
    do_load(1, DEPTH, 80);
    cyc();
    do_load(5, 0, 80);

    // Zero-length load and out-of-range fetch.
    do_load(300, 0, 80);
    rand_fetch = 1'b0;
    stall = 1'b0;
    addr = 30'h400; cyc(); cyc();
    addr = 30'h3FFF_FFFF; cyc();
    addr = 30'd1023; cyc();

    // Reset after two of four words.
    hot_base = 100;
    ld_start = 1'b1; ld_base = 10'd100; ld_count = 11'd4; cyc();
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 32'h1111_0100; cyc();
    ld_data  = 32'h2222_0101; cyc();
    ld_valid = 1'b0; rst = 1'b1; cyc();
    rst = 1'b0; cyc();
    for (int a = 100; a < 104; a++) begin
      addr = ADDR_W'(a); cyc();
    end

    // Randomised loads with random fetch traffic.
    rand_fetch = 1'b1;
    repeat (60) begin
      base = $urandom_range(0, DEPTH - 1);
      case ($urandom_range(0, 5))
        0:       count = 0;
        1:       count = $urandom_range(0, DEPTH);
        2:       count = DEPTH - base + $urandom_range(0, 2);
        default: count = $urandom_range(1, 16);
      endcase
      do_load(base, count, $urandom_range(40, 100));
      repeat ($urandom_range(0, 3)) cyc();
    end
    for (int i = 0; i < 40; i++) cyc();

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
